// File: rtl/door_ctrl_pkg.sv
// Shared types for the multi-door controller: per-door state encoding and motion direction.
package door_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10,
        FAULT = 2'b11
    } door_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/door_channel.sv
// One garage door: edge-detected activate, IDLE/MV_UP/MV_DN/FAULT FSM, travel timer and direction memory.
// Optional timed auto-close of an idle open door is built only when DOOR_AUTO_CLOSE_EN is defined.
//
// state | meaning
// IDLE  | motors off, waiting for a command (or auto-close timeout)
// MV_UP | open motor driven until UP_Max, timeout, or stop command
// MV_DN | close motor driven until DN_Max, timeout, obstruction or stop
// FAULT | motors off, held until clr_fault
module door_channel
    import door_ctrl_pkg::*;
#(
    parameter int TRAVEL_TIMEOUT    = 1024,
    parameter int AUTO_CLOSE_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic activate,
    input  logic up_max,
    input  logic dn_max,
    input  logic obstruct,
    input  logic clr_fault,
    output logic up_m,
    output logic dn_m,
    output logic fault
);

    localparam int CNT_W = $clog2(max_int(TRAVEL_TIMEOUT, AUTO_CLOSE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
`ifdef DOOR_AUTO_CLOSE_EN
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CLOSE_CYCLES - 1);
`endif

    door_state_e      state, next_state;
    logic             act_q;
    logic             cmd;
    logic             last_dir, next_dir;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             moving_next;

    // act_q resets high so a button held through reset release is not a command
    assign cmd = activate & ~act_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            act_q    <= 1'b1;
            last_dir <= DIR_DN;
            cnt      <= '0;
        end else begin
            state    <= next_state;
            act_q    <= activate;
            last_dir <= next_dir;
            cnt      <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd) begin
                    if (up_max && dn_max)
                        next_state = FAULT;
                    else if (dn_max)
                        next_state = MV_UP;
                    else if (up_max) begin
                        if (!obstruct)
                            next_state = MV_DN;
                    end else if (last_dir == DIR_DN)
                        next_state = MV_UP;
                    else if (!obstruct)
                        next_state = MV_DN;
                end
`ifdef DOOR_AUTO_CLOSE_EN
                else if (up_max && !obstruct && cnt == AUTO_LAST)
                    next_state = MV_DN;
`endif
            end
            MV_UP: begin
                if (up_max && dn_max)
                    next_state = FAULT;
                else if (up_max)
                    next_state = IDLE;
                else if (cnt == TRAVEL_LAST)
                    next_state = FAULT;
                else if (cmd)
                    next_state = IDLE;
            end
            MV_DN: begin
                if (up_max && dn_max)
                    next_state = FAULT;
                else if (dn_max)
                    next_state = IDLE;
                else if (cnt == TRAVEL_LAST)
                    next_state = FAULT;
                else if (obstruct)
                    next_state = MV_UP;
                else if (cmd)
                    next_state = IDLE;
            end
            FAULT: begin
                if (clr_fault)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign moving_next = (next_state == MV_UP) || (next_state == MV_DN);

    always_comb begin
        next_dir = last_dir;
        if (next_state == MV_UP)
            next_dir = DIR_UP;
        else if (next_state == MV_DN)
            next_dir = DIR_DN;
    end

    // Counter restarts on any state change, so a reversal gets a full travel budget
    always_comb begin
        next_cnt = '0;
        if (moving_next && next_state == state)
            next_cnt = cnt + CNT_W'(1);
`ifdef DOOR_AUTO_CLOSE_EN
        if (state == IDLE && next_state == IDLE && up_max && !obstruct && !cmd)
            next_cnt = cnt + CNT_W'(1);
`endif
    end

    assign up_m  = (state == MV_UP);
    assign dn_m  = (state == MV_DN);
    assign fault = (state == FAULT);

endmodule

// File: rtl/multi_door_controller.sv
// NUM_DOORS independent door channels sharing one clock and reset; per-door outputs are bit-concatenated.
// Build with DOOR_AUTO_CLOSE_EN defined to add timed auto-close to every channel.
module multi_door_controller
    import door_ctrl_pkg::*;
#(
    parameter int NUM_DOORS         = 2,
    parameter int TRAVEL_TIMEOUT    = 1024,
    parameter int AUTO_CLOSE_CYCLES = 4096
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_DOORS-1:0] Activate,
    input  logic [NUM_DOORS-1:0] UP_Max,
    input  logic [NUM_DOORS-1:0] DN_Max,
    input  logic [NUM_DOORS-1:0] Obstruct,
    input  logic [NUM_DOORS-1:0] Clr_Fault,
    output logic [NUM_DOORS-1:0] UP_M,
    output logic [NUM_DOORS-1:0] DN_M,
    output logic [NUM_DOORS-1:0] Fault
);

    for (genvar i = 0; i < NUM_DOORS; i++) begin : g_door
        door_channel #(
            .TRAVEL_TIMEOUT   (TRAVEL_TIMEOUT),
            .AUTO_CLOSE_CYCLES(AUTO_CLOSE_CYCLES)
        ) u_channel (
            .clk      (CLK),
            .rst      (RST),
            .activate (Activate[i]),
            .up_max   (UP_Max[i]),
            .dn_max   (DN_Max[i]),
            .obstruct (Obstruct[i]),
            .clr_fault(Clr_Fault[i]),
            .up_m     (UP_M[i]),
            .dn_m     (DN_M[i]),
            .fault    (Fault[i])
        );
    end

endmodule

// File: tb/tb_multi_door_controller.sv
// Bench for multi_door_controller: two doors, TRAVEL_TIMEOUT=8, AUTO_CLOSE_CYCLES=4.
module tb_multi_door_controller;

    localparam int ND = 2;

    logic          CLK;
    logic          RST;
    logic [ND-1:0] Activate, UP_Max, DN_Max, Obstruct, Clr_Fault;
    logic [ND-1:0] UP_M, DN_M, Fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string     name;
        logic [1:0] act, lu, ld, obs, clr;
        logic [1:0] eu, ed, ef;
    } vec_t;

    typedef struct {
        string     name;
        logic [1:0] eu, ed, ef;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    multi_door_controller #(
        .NUM_DOORS        (ND),
        .TRAVEL_TIMEOUT   (8),
        .AUTO_CLOSE_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Activate (Activate),
        .UP_Max   (UP_Max),
        .DN_Max   (DN_Max),
        .Obstruct (Obstruct),
        .Clr_Fault(Clr_Fault),
        .UP_M     (UP_M),
        .DN_M     (DN_M),
        .Fault    (Fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void add(input string name, input logic [1:0] act, lu, ld, obs, clr,
                                input logic [1:0] eu, ed, ef);
        vec_t v;
        v.name = name; v.act = act; v.lu = lu; v.ld = ld; v.obs = obs; v.clr = clr;
        v.eu = eu; v.ed = ed; v.ef = ef;
        tbl.push_back(v);
    endfunction

    function automatic void expect_out(input string name, input logic [1:0] eu, ed, ef);
        exp_t e;
        e.name = name; e.eu = eu; e.ed = ed; e.ef = ef;
        sb.push_back(e);
    endfunction

    task automatic compare_one();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry, UP_M=%b DN_M=%b Fault=%b", UP_M, DN_M, Fault);
        end else begin
            e = sb.pop_front();
            if ({UP_M, DN_M, Fault} !== {e.eu, e.ed, e.ef}) begin
                errors++;
                $display("FAIL %s @%0t: got UP_M=%b DN_M=%b Fault=%b, expected UP_M=%b DN_M=%b Fault=%b",
                         e.name, $time, UP_M, DN_M, Fault, e.eu, e.ed, e.ef);
            end
        end
    endtask

    // Drive inputs for one cycle, then compare outputs just after the edge
    task automatic apply(input string name, input logic [1:0] act, lu, ld, obs, clr,
                         input logic [1:0] eu, ed, ef);
        Activate  = act;
        UP_Max    = lu;
        DN_Max    = ld;
        Obstruct  = obs;
        Clr_Fault = clr;
        expect_out(name, eu, ed, ef);
        @(posedge CLK);
        #1;
        compare_one();
    endtask

    initial begin
        // name              act    up     dn     obs    clr    UP_M   DN_M   Fault
        add("hold_act_no_cmd", 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("hold_act_no_cmd", 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("act_release",     2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("open_start",      2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add("opening_held",    2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add("opening",         2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add("open_limit",      2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("close_start",     2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add("closing",         2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add("obstruct_reverse",2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add("reopening",       2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add("stop_mid",        2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("stopped",         2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("resume_opposite", 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add("closing2",        2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add("stop_mid2",       2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("stopped2",        2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        RST = 1'b1;
        Activate = 2'b11; UP_Max = 2'b00; DN_Max = 2'b11; Obstruct = 2'b00; Clr_Fault = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        expect_out("reset_state", 2'b00, 2'b00, 2'b00);
        compare_one();
        RST = 1'b0;

        foreach (tbl[i])
            apply(tbl[i].name, tbl[i].act, tbl[i].lu, tbl[i].ld, tbl[i].obs, tbl[i].clr,
                  tbl[i].eu, tbl[i].ed, tbl[i].ef);

        // Travel timeout: motor high for exactly 8 cycles, then fault
        apply("to_start", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 7; i++)
            apply("to_run", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        apply("to_fault", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        apply("fault_ignores_cmd", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        apply("fault_hold",        2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);

        // Clear door0 while door1 starts opening in the same cycle
        apply("clr_and_door1_open", 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
        apply("door1_open_limit",   2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("door1_idle",         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Reversal restarts the travel counter: 8 more cycles of UP_M before fault
        apply("rev_close_start", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        apply("rev_closing",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        apply("rev_closing",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        apply("rev_restart",     2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 7; i++)
            apply("rev_run", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        apply("rev_timeout", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        apply("rev_clear",   2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

        // Limit on the final timeout edge wins over the fault
        apply("tie_start", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        for (int i = 0; i < 7; i++)
            apply("tie_run", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        apply("tie_limit_wins", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        apply("obs_blocks_close", 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("obs_idle_open",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        apply("both_limits_fault", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        apply("both_limits_clear", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

        // Asynchronous reset while closing drops the motor without a clock edge
        apply("rst_close_start", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        apply("rst_closing",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        #2;
        RST = 1'b1;
        #1;
        expect_out("rst_async", 2'b00, 2'b00, 2'b00);
        compare_one();
        Activate = 2'b00; UP_Max = 2'b00; DN_Max = 2'b00; Obstruct = 2'b00; Clr_Fault = 2'b00;
        @(posedge CLK);
        #1;
        RST = 1'b0;

`ifdef DOOR_AUTO_CLOSE_EN
        for (int i = 0; i < 3; i++)
            apply("ac_wait", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("ac_close", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        apply("ac_stop",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("ac_wait2", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("ac_wait2", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("ac_obs",   2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++)
            apply("ac_obs_restart", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        apply("ac_close2", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
`else
        for (int i = 0; i < 10; i++)
            apply("no_auto_close", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_door_controller.md
# multi_door_controller

Parametrised controller for NUM_DOORS independent garage doors, each with its own up/down motor drive, limit sensors, push-button activate and obstruction sensor. Per door: edge-triggered activate with stop-in-travel and direction memory, obstruction reversal while closing, travel-timeout fault with explicit clear, and optional timed auto-close. Sits between the debounced sensor/button inputs and the motor driver stage; replaces the single-door level-activated controller.

## Interface
- NUM_DOORS, 2: number of independent door channels (≥1).
- TRAVEL_TIMEOUT, 1024: maximum cycles a motor may run without reaching the target limit (≥2).
- AUTO_CLOSE_CYCLES, 4096: idle-open cycles before auto-close (≥1; used only with DOOR_AUTO_CLOSE_EN).
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Activate  input  NUM_DOORS  push-button per door; a rising edge is one command.
- UP_Max  input  NUM_DOORS  door fully open limit.
- DN_Max  input  NUM_DOORS  door fully closed limit.
- Obstruct  input  NUM_DOORS  obstruction beam broken.
- Clr_Fault  input  NUM_DOORS  level; returns a faulted door to IDLE.
- UP_M  output  NUM_DOORS  open motor drive.
- DN_M  output  NUM_DOORS  close motor drive.
- Fault  output  NUM_DOORS  door in FAULT.

## Operation
- Per-door FSM states: IDLE, MV_UP, MV_DN, FAULT. Outputs decode state only: UP_M=MV_UP, DN_M=MV_DN, Fault=FAULT; never both motors high.
- Command pulse cmd = Activate & ~act_q; act_q resets to 1, so Activate held high across reset release issues no command.
- last_dir register (UP/DN) records direction of most recent motion; resets to DN.
- IDLE on cmd: UP_Max&DN_Max -> FAULT; DN_Max -> MV_UP; UP_Max -> MV_DN unless Obstruct (then stay IDLE); neither -> opposite of last_dir (DN direction also blocked by Obstruct).
- MV_UP/MV_DN priority, highest first: both limits -> FAULT; target limit (UP_Max in MV_UP, DN_Max in MV_DN) -> IDLE; travel counter == TRAVEL_TIMEOUT-1 -> FAULT; MV_DN & Obstruct -> MV_UP; cmd -> IDLE (stop mid-travel).
- Travel counter clears on every entry to MV_UP/MV_DN (including reversal), increments each cycle in motion; width $clog2(max(TRAVEL_TIMEOUT, AUTO_CLOSE_CYCLES)+1), no wrap reachable.
- FAULT: motors off; leaves only on Clr_Fault (-> IDLE) or RST. cmd ignored in FAULT.
- Channels fully independent; simultaneous events on different doors never interact.

## Timing
- Reset values: UP_M=0, DN_M=0, Fault=0, state=IDLE, counters 0, last_dir=DN, act_q=1. RST mid-travel drops motors asynchronously.
- Latency: Activate rising before edge k -> cmd at edge k -> state change at edge k -> motor output valid after edge k (one edge from input to output).
- Limit/Obstruct/Clr_Fault sampled at each edge; response visible after that same edge.
- Timeout: motor output high for exactly TRAVEL_TIMEOUT cycles, then Fault=1 the next cycle, unless a limit arrives at or before the final edge (limit wins on tie).

## Configuration
- DOOR_AUTO_CLOSE_EN defined: in IDLE with UP_Max=1, Obstruct=0, the counter increments; at AUTO_CLOSE_CYCLES-1 the door enters MV_DN. cmd, Obstruct or loss of UP_Max clears the counter.
- Undefined: open door stays open indefinitely; AUTO_CLOSE_CYCLES unused; no auto-close logic synthesised.

## Structure
- Package door_ctrl_pkg: state enum (IDLE=2'b00, MV_UP=2'b01, MV_DN=2'b10, FAULT=2'b11), direction constants DIR_UP/DIR_DN.
- Sub-module door_channel: one FSM, edge detector, counter, last_dir; top generates NUM_DOORS instances and concatenates outputs.

## Test plan
- NUM_DOORS=2, TRAVEL_TIMEOUT=8. Door0 DN_Max=1, Activate 0->1 -> UP_M[0]=1 one edge later; UP_Max=1 at cycle 5 -> UP_M[0]=0 next edge, Fault=0.
- Door0 open, cmd -> MV_DN; Obstruct=1 at cycle 3 -> DN_M[0]=0, UP_M[0]=1 next edge, counter restarted.
- Mid-travel cmd -> IDLE; next cmd with no limits -> opposite direction of last motion.
- No limit reached: UP_M[0] high exactly 8 cycles, then Fault[0]=1; Clr_Fault[0]=1 -> Fault[0]=0, IDLE; door1 unaffected throughout.
- UP_Max=DN_Max=1 with cmd -> Fault; Activate held high through RST deassert -> no motion; RST during MV_DN -> DN_M=0 immediately.
- DOOR_AUTO_CLOSE_EN, AUTO_CLOSE_CYCLES=4: door open, idle -> DN_M=1 after 4 cycles; Obstruct pulse restarts count.
